// File: rtl/frame_scheduler.sv
// Runs N_STAGES one-hot req/ack update stages once per frame, starting at vblank; aborts at visible start.
// Outputs registered: VB in cycle c -> frame_tick/stage_req[0] in c+1; ack in c -> next req in c+1.
module frame_scheduler #(
  parameter int N_STAGES  = 3,
  parameter int V_DISPLAY = 480,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                p_tick,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic                enable,
  input  logic                clear_overrun,
  input  logic [N_STAGES-1:0] stage_ack,
  output logic [N_STAGES-1:0] stage_req,
  output logic                frame_tick,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic [CNT_W-1:0]    frame_cnt
);

  localparam int KW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [N_STAGES-1:0] REQ_ONE = N_STAGES'(1);
  localparam logic [KW-1:0]       K_LAST  = KW'(N_STAGES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [KW-1:0]       r_k, w_k_nxt;
  logic                w_vb, w_vs, w_abort;
  logic [N_STAGES-1:0] r_stage_req;
  logic                r_frame_tick, r_busy, r_done, r_overrun;
  logic [CNT_W-1:0]    r_frame_cnt;

  always_comb begin
    w_vb = p_tick && (x == 10'd0) && (y == 10'(V_DISPLAY));
    w_vs = p_tick && (x == 10'd0) && (y == 10'd0);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_vb && enable) begin
          w_state_nxt = S_RUN;
          w_k_nxt     = '0;
        end
      end
      S_RUN: begin
        // Visible start wins over a same-cycle ack: the frame is already lost.
        if (w_vs) begin
          w_state_nxt = S_IDLE;
          w_k_nxt     = '0;
          w_abort     = 1'b1;
        end else if (stage_ack[r_k]) begin
          if (r_k == K_LAST) begin
            w_state_nxt = S_DONE;
            w_k_nxt     = '0;
          end else begin
            w_k_nxt = r_k + KW'(1);
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt = S_IDLE;
        w_k_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_stage_req  <= '0;
      r_frame_tick <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_k          <= w_k_nxt;
      r_stage_req  <= (w_state_nxt == S_RUN) ? (REQ_ONE << w_k_nxt) : '0;
      r_frame_tick <= w_vb;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_DONE);
      if (w_abort)
        r_overrun <= 1'b1;
      else if (clear_overrun)
        r_overrun <= 1'b0;
      if (w_vb)
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

  assign stage_req  = r_stage_req;
  assign frame_tick = r_frame_tick;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overrun    = r_overrun;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: vector table plus hand sequences for waits, aborts, wrap and reset.
module tb_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_tick;
  logic [9:0]  x, y;
  logic        enable, clear_overrun;
  logic [2:0]  stage_ack, stage_req;
  logic        frame_tick, busy, done, overrun;
  logic [15:0] frame_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  frame_scheduler #(.N_STAGES(3), .V_DISPLAY(480), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .p_tick(p_tick), .x(x), .y(y),
    .enable(enable), .clear_overrun(clear_overrun), .stage_ack(stage_ack),
    .stage_req(stage_req), .frame_tick(frame_tick), .busy(busy), .done(done),
    .overrun(overrun), .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic        pt;
    logic [9:0]  vx, vy;
    logic        en, clr;
    logic [2:0]  ack;
    logic [2:0]  e_req;
    logic        e_ft, e_busy, e_done, e_ov;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic pt, input int vx, input int vy, input logic en,
                              input logic clr, input logic [2:0] ack, input logic [2:0] e_req,
                              input logic e_ft, input logic e_busy, input logic e_done,
                              input logic e_ov, input int e_cnt);
    vec_t v;
    v.pt = pt; v.vx = 10'(vx); v.vy = 10'(vy); v.en = en; v.clr = clr; v.ack = ack;
    v.e_req = e_req; v.e_ft = e_ft; v.e_busy = e_busy; v.e_done = e_done; v.e_ov = e_ov;
    v.e_cnt = 16'(e_cnt);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    p_tick = 1'b0; x = 10'd5; y = 10'd100; enable = 1'b0;
    clear_overrun = 1'b0; stage_ack = 3'b000;
  endtask

  task automatic drive_vb(input logic en);
    p_tick = 1'b1; x = 10'd0; y = 10'd480; enable = en;
  endtask

  task automatic drive_vs();
    p_tick = 1'b1; x = 10'd0; y = 10'd0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Stage acks are raised d cycles after each req rises; done must land 3*(d+1) cycles after frame_tick.
  task automatic run_seq(input int d, input string nm);
    int cnt, done_t;
    logic [2:0] prev;
    logic [2:0] seq[$];
    bit multi;
    drive_vb(1'b1);
    cyc();
    idle_in();
    chk({nm, " frame_tick"}, 64'(frame_tick), 64'd1);
    chk({nm, " first req"}, 64'(stage_req), 64'b001);
    prev = stage_req; seq.push_back(stage_req);
    cnt = 0; done_t = -1; multi = 1'b0;
    for (int t = 1; t <= 400; t++) begin
      stage_ack = (stage_req != 3'b000 && cnt == d) ? stage_req : 3'b000;
      cyc();
      stage_ack = 3'b000;
      if ($countones(stage_req) > 1) multi = 1'b1;
      if (done) begin
        done_t = t;
        break;
      end
      if (stage_req != prev) begin
        seq.push_back(stage_req);
        cnt = 0;
      end else begin
        cnt++;
      end
      prev = stage_req;
    end
    chk({nm, " done latency"}, 64'(done_t), 64'(3 * (d + 1)));
    chk({nm, " req count"}, 64'(seq.size()), 64'd3);
    if (seq.size() == 3)
      chk({nm, " req order"}, 64'({seq[0], seq[1], seq[2]}), 64'({3'b001, 3'b010, 3'b100}));
    chk({nm, " no multi-hot"}, 64'(multi), 64'd0);
    chk({nm, " req at done"}, 64'(stage_req), 64'd0);
    cyc();
    chk({nm, " busy after done"}, 64'({busy, done}), 64'd0);
  endtask

  vec_t vt[18];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    bit req_seen;

    vt[0]  = mk(0, 0,   0, 1, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 0, 480, 1, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
    vt[2]  = mk(1, 1, 480, 1, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
    vt[3]  = mk(1, 0, 479, 1, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
    vt[4]  = mk(1, 0, 480, 1, 0, 3'b000, 3'b001, 1, 1, 0, 0, 1);
    vt[5]  = mk(0, 5, 100, 0, 0, 3'b000, 3'b001, 0, 1, 0, 0, 1);
    vt[6]  = mk(0, 5, 100, 0, 0, 3'b110, 3'b001, 0, 1, 0, 0, 1);
    vt[7]  = mk(0, 5, 100, 0, 0, 3'b001, 3'b010, 0, 1, 0, 0, 1);
    vt[8]  = mk(0, 5, 100, 0, 0, 3'b101, 3'b010, 0, 1, 0, 0, 1);
    vt[9]  = mk(0, 5, 100, 0, 0, 3'b010, 3'b100, 0, 1, 0, 0, 1);
    vt[10] = mk(0, 5, 100, 0, 0, 3'b100, 3'b000, 0, 1, 1, 0, 1);
    vt[11] = mk(0, 5, 100, 0, 0, 3'b100, 3'b000, 0, 0, 0, 0, 1);
    vt[12] = mk(1, 0, 480, 0, 0, 3'b000, 3'b000, 1, 0, 0, 0, 2);
    vt[13] = mk(1, 0, 480, 1, 0, 3'b000, 3'b001, 1, 1, 0, 0, 3);
    vt[14] = mk(0, 5, 100, 0, 0, 3'b001, 3'b010, 0, 1, 0, 0, 3);
    vt[15] = mk(1, 0,   0, 0, 0, 3'b010, 3'b000, 0, 0, 0, 1, 3);
    vt[16] = mk(0, 5, 100, 0, 0, 3'b000, 3'b000, 0, 0, 0, 1, 3);
    vt[17] = mk(0, 5, 100, 0, 1, 3'b000, 3'b000, 0, 0, 0, 0, 3);

    do_reset();
    chk("reset outputs", 64'({stage_req, frame_tick, busy, done, overrun, frame_cnt}), 64'd0);

    run_seq(5, "wait5");
    chk("wait5 frame_cnt", 64'(frame_cnt), 64'd1);
    chk("wait5 overrun", 64'(overrun), 64'd0);
    run_seq(0, "wait0");

    do_reset();
    for (int i = 0; i < 18; i++) begin
      p_tick = vt[i].pt; x = vt[i].vx; y = vt[i].vy; enable = vt[i].en;
      clear_overrun = vt[i].clr; stage_ack = vt[i].ack;
      cyc();
      chk($sformatf("vec%0d", i),
          64'({stage_req, frame_tick, busy, done, overrun, frame_cnt}),
          64'({vt[i].e_req, vt[i].e_ft, vt[i].e_busy, vt[i].e_done, vt[i].e_ov, vt[i].e_cnt}));
    end
    idle_in();

    // Stage 1 is never acknowledged; visible start must abort the sequence.
    drive_vb(1'b1); cyc(); idle_in();
    stage_ack = 3'b001; cyc(); stage_ack = 3'b000;
    repeat (10) cyc();
    chk("stall holds req1", 64'({stage_req, busy}), 64'({3'b010, 1'b1}));
    drive_vs(); stage_ack = 3'b010; cyc(); idle_in();
    chk("abort outputs", 64'({stage_req, busy, overrun}), 64'({3'b000, 1'b0, 1'b1}));
    repeat (5) cyc();
    chk("overrun sticky", 64'(overrun), 64'd1);
    clear_overrun = 1'b1; cyc(); idle_in();
    chk("overrun cleared", 64'(overrun), 64'd0);
    drive_vs(); cyc(); idle_in();
    chk("vs in idle no overrun", 64'({overrun, busy}), 64'd0);
    drive_vb(1'b1); cyc(); idle_in();
    drive_vs(); clear_overrun = 1'b1; cyc(); idle_in();
    chk("set beats clear", 64'({overrun, busy, stage_req}), 64'({1'b1, 1'b0, 3'b000}));

    // Disabled: three frames tick and count but never request a stage.
    do_reset();
    ticks = 0; req_seen = 1'b0;
    for (int f = 0; f < 3; f++) begin
      drive_vb(1'b0); cyc(); idle_in();
      if (frame_tick) ticks++;
      if (stage_req != 3'b000 || busy) req_seen = 1'b1;
      for (int c = 0; c < 20; c++) begin
        cyc();
        if (frame_tick) ticks++;
        if (stage_req != 3'b000 || busy) req_seen = 1'b1;
      end
      drive_vs(); cyc(); idle_in();
      if (frame_tick) ticks++;
      if (stage_req != 3'b000 || busy) req_seen = 1'b1;
    end
    chk("disabled ticks", 64'(ticks), 64'd3);
    chk("disabled no req", 64'(req_seen), 64'd0);
    chk("disabled frame_cnt", 64'(frame_cnt), 64'd3);

    // Asynchronous reset in the middle of a sequence.
    drive_vb(1'b1); cyc(); idle_in();
    stage_ack = 3'b001; cyc(); stage_ack = 3'b000;
    chk("pre-reset running", 64'({stage_req, busy}), 64'({3'b010, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs", 64'({stage_req, frame_tick, busy, done, overrun, frame_cnt}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    stage_ack = 3'b010;
    repeat (3) cyc();
    stage_ack = 3'b000;
    chk("post-reset waits for VB", 64'({stage_req, busy, frame_cnt}), 64'd0);

    // Counter wrap: one VB per cycle with enable low.
    drive_vb(1'b0);
    repeat (65535) @(posedge clk);
    #1;
    chk("frame_cnt max", 64'(frame_cnt), 64'hFFFF);
    cyc();
    idle_in();
    chk("frame_cnt wrap", 64'({frame_tick, frame_cnt}), 64'({1'b1, 16'h0000}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
